// File: rtl/quad_counter.sv
// -----------------------------------------------------------------------------
// quad_counter
//
// Quadrature encoder decoder with a bounded position counter.
//
// The two encoder phases form a 2-bit state AB = {i_phase_a, i_phase_b} that
// walks 00 -> 10 -> 11 -> 01 -> 00 when turning clockwise and the reverse way
// when turning counter-clockwise. Every single-bit change moves a signed
// sub-counter one way or the other. When the sub-counter reaches +/-p_STEPS a
// detent is reported and the position count moves by one, either wrapping or
// saturating at the [p_MIN, p_MAX] limits. A change of both bits at once cannot
// come from a real encoder and is reported as an error.
//
// Parameters
//   p_WIDTH      position counter width
//   p_MIN        lowest count value (unsigned)
//   p_MAX        highest count value (unsigned), p_MIN < p_MAX < 2**p_WIDTH
//   p_INIT       count value after reset, p_MIN <= p_INIT <= p_MAX
//   p_MODE       0 = wrap at the limits, 1 = saturate at the limits
//   p_STEPS      valid transitions per detent (1, 2 or 4)
//   p_ERR_WIDTH  error counter width
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-high reset
//   i_phase_a      encoder phase A, already synchronised to clk
//   i_phase_b      encoder phase B, already synchronised to clk
//   i_load         single-cycle strobe: load iv_load_value (clamped)
//   iv_load_value  value to load
//   i_clear_err    clears the error counter
//   ov_count       current position count
//   o_step         one-cycle pulse per completed detent
//   o_cw           direction of the last detent (1 = CW), held between steps
//   o_err          one-cycle pulse on an illegal transition
//   ov_err_cnt     saturating count of illegal transitions
//   o_at_min       high while ov_count == p_MIN
//   o_at_max       high while ov_count == p_MAX
// -----------------------------------------------------------------------------

`default_nettype none

module quad_counter #(
    parameter int unsigned p_WIDTH     = 8,
    parameter int unsigned p_MIN       = 0,
    parameter int unsigned p_MAX       = 255,
    parameter int unsigned p_INIT      = 0,
    parameter int unsigned p_MODE      = 0,
    parameter int unsigned p_STEPS     = 4,
    parameter int unsigned p_ERR_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_phase_a,
    input  logic                   i_phase_b,
    input  logic                   i_load,
    input  logic [p_WIDTH-1:0]     iv_load_value,
    input  logic                   i_clear_err,
    output logic [p_WIDTH-1:0]     ov_count,
    output logic                   o_step,
    output logic                   o_cw,
    output logic                   o_err,
    output logic [p_ERR_WIDTH-1:0] ov_err_cnt,
    output logic                   o_at_min,
    output logic                   o_at_max
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------

    // Count arithmetic runs one bit wider than the count so that +1 at
    // p_MAX = 2**p_WIDTH - 1 does not fold back to zero.
    localparam int unsigned L_EXT_W = p_WIDTH + 1;

    // Load clamping uses two extra bits: the top bit is the borrow of a
    // subtraction and tells which side of a limit the load value is on.
    localparam int unsigned L_CMP_W = p_WIDTH + 2;

    // Signed sub-counter wide enough to hold +/-p_STEPS.
    localparam int unsigned L_SUB_W = $clog2(p_STEPS + 1) + 1;

    localparam logic [p_WIDTH-1:0] L_MIN  = p_WIDTH'(p_MIN);
    localparam logic [p_WIDTH-1:0] L_MAX  = p_WIDTH'(p_MAX);
    localparam logic [p_WIDTH-1:0] L_INIT = p_WIDTH'(p_INIT);

    localparam logic [L_EXT_W-1:0] L_EXT_ONE = L_EXT_W'(1);
    localparam logic [L_CMP_W-1:0] L_CMP_MIN = L_CMP_W'(p_MIN);
    localparam logic [L_CMP_W-1:0] L_CMP_MAX = L_CMP_W'(p_MAX);

    localparam logic signed [L_SUB_W-1:0] L_SUB_ONE = L_SUB_W'(1);
    localparam logic signed [L_SUB_W-1:0] L_SUB_POS = L_SUB_W'(p_STEPS);
    localparam logic signed [L_SUB_W-1:0] L_SUB_NEG = -L_SUB_POS;

    localparam logic [p_ERR_WIDTH-1:0] L_ERR_SAT = '1;

    localparam bit L_WRAP = (p_MODE == 0);

    // Classification of one sample of AB against the previous sample.
    typedef enum logic [1:0] {
        TR_NONE,     // AB unchanged
        TR_CW,       // one bit changed, clockwise order
        TR_CCW,      // one bit changed, counter-clockwise order
        TR_ILLEGAL   // both bits changed
    } trans_e;

    // Next AB state when turning clockwise: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] f_cw_next(input logic [1:0] ab);
        logic [1:0] nxt;
        case (ab)
            2'b00:   nxt = 2'b10;
            2'b10:   nxt = 2'b11;
            2'b11:   nxt = 2'b01;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    function automatic trans_e f_classify(input logic [1:0] prev,
                                          input logic [1:0] cur);
        trans_e kind;
        if (prev == cur) begin
            kind = TR_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            kind = TR_ILLEGAL;
        end else if (cur == f_cw_next(prev)) begin
            kind = TR_CW;
        end else begin
            kind = TR_CCW;
        end
        return kind;
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------

    logic [1:0]                r_prev_ab;
    logic                      r_primed;   // r_prev_ab holds a real sample
    logic signed [L_SUB_W-1:0] r_sub;
    logic [p_WIDTH-1:0]        r_count;
    logic                      r_step;
    logic                      r_cw;
    logic                      r_err;
    logic [p_ERR_WIDTH-1:0]    r_err_cnt;

    // -------------------------------------------------------------------------
    // Transition decode
    // -------------------------------------------------------------------------

    logic [1:0] w_ab;
    trans_e     w_trans;

    assign w_ab    = {i_phase_a, i_phase_b};
    assign w_trans = f_classify(r_prev_ab, w_ab);

    // -------------------------------------------------------------------------
    // Sub-counter and detent detection
    // -------------------------------------------------------------------------

    logic signed [L_SUB_W-1:0] w_sub_inc;
    logic signed [L_SUB_W-1:0] w_sub_dec;
    logic signed [L_SUB_W-1:0] w_sub_nxt;
    logic                      w_detent;
    logic                      w_detent_cw;

    assign w_sub_inc = r_sub + L_SUB_ONE;
    assign w_sub_dec = r_sub - L_SUB_ONE;

    always_comb begin
        // NOTE: every signal driven here gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        w_sub_nxt   = r_sub;
        w_detent    = 1'b0;
        w_detent_cw = 1'b0;

        case (w_trans)
            TR_CW: begin
                if (w_sub_inc == L_SUB_POS) begin
                    w_sub_nxt   = '0;
                    w_detent    = 1'b1;
                    w_detent_cw = 1'b1;
                end else begin
                    w_sub_nxt = w_sub_inc;
                end
            end
            TR_CCW: begin
                if (w_sub_dec == L_SUB_NEG) begin
                    w_sub_nxt = '0;
                    w_detent  = 1'b1;
                end else begin
                    w_sub_nxt = w_sub_dec;
                end
            end
            // A glitch or missed sample: forget any partial detent.
            TR_ILLEGAL: w_sub_nxt = '0;
            default:    w_sub_nxt = r_sub;
        endcase
    end

    // -------------------------------------------------------------------------
    // Count candidates: one step up, one step down, and the clamped load value
    // -------------------------------------------------------------------------

    logic [L_EXT_W-1:0] w_count_ext;
    logic [L_EXT_W-1:0] w_up_ext;
    logic [L_EXT_W-1:0] w_dn_ext;
    logic [p_WIDTH-1:0] w_count_up;
    logic [p_WIDTH-1:0] w_count_dn;

    assign w_count_ext = {1'b0, r_count};
    assign w_up_ext    = w_count_ext + L_EXT_ONE;
    assign w_dn_ext    = w_count_ext - L_EXT_ONE;

    always_comb begin
        w_count_up = w_up_ext[p_WIDTH-1:0];
        if (r_count == L_MAX) begin
            w_count_up = L_WRAP ? L_MIN : L_MAX;
        end
    end

    always_comb begin
        w_count_dn = w_dn_ext[p_WIDTH-1:0];
        if (r_count == L_MIN) begin
            w_count_dn = L_WRAP ? L_MAX : L_MIN;
        end
    end

    logic [L_CMP_W-1:0] w_load_cmp;
    logic [L_CMP_W-1:0] w_load_minus_min;
    logic [L_CMP_W-1:0] w_max_minus_load;
    logic               w_load_below_min;
    logic               w_load_above_max;
    logic [p_WIDTH-1:0] w_count_load;

    assign w_load_cmp       = {2'b00, iv_load_value};
    assign w_load_minus_min = w_load_cmp - L_CMP_MIN;
    assign w_max_minus_load = L_CMP_MAX - w_load_cmp;
    assign w_load_below_min = w_load_minus_min[L_CMP_W-1];
    assign w_load_above_max = w_max_minus_load[L_CMP_W-1];

    always_comb begin
        w_count_load = iv_load_value;
        if (w_load_below_min) begin
            w_count_load = L_MIN;
        end else if (w_load_above_max) begin
            w_count_load = L_MAX;
        end
    end

    // -------------------------------------------------------------------------
    // Error counter: clear wins over a simultaneous error, otherwise saturate
    // -------------------------------------------------------------------------

    logic [p_ERR_WIDTH-1:0] w_err_cnt_nxt;

    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (i_clear_err) begin
            w_err_cnt_nxt = '0;
        end else if ((w_trans == TR_ILLEGAL) && (r_err_cnt != L_ERR_SAT)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_ab <= 2'b00;
            r_primed  <= 1'b0;
            r_sub     <= '0;
            r_count   <= L_INIT;
            r_step    <= 1'b0;
            r_cw      <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register is
            // computed from the values sampled at this edge regardless of the
            // statement order below.
            r_prev_ab <= w_ab;
            r_step    <= 1'b0;
            r_err     <= 1'b0;

            if (!r_primed) begin
                // r_prev_ab still holds its reset value, not a real sample;
                // comparing against it could fake a step or an error.
                r_primed <= 1'b1;
            end else begin
                r_err     <= (w_trans == TR_ILLEGAL);
                r_err_cnt <= w_err_cnt_nxt;

                if (i_load) begin
                    // A detent completing on this edge is dropped.
                    r_count <= w_count_load;
                    r_sub   <= '0;
                end else begin
                    r_sub <= w_sub_nxt;
                    if (w_detent) begin
                        r_step  <= 1'b1;
                        r_cw    <= w_detent_cw;
                        r_count <= w_detent_cw ? w_count_up : w_count_dn;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------

    assign ov_count   = r_count;
    assign o_step     = r_step;
    assign o_cw       = r_cw;
    assign o_err      = r_err;
    assign ov_err_cnt = r_err_cnt;
    assign o_at_min   = (r_count == L_MIN);
    assign o_at_max   = (r_count == L_MAX);

endmodule

`default_nettype wire

// File: tb/tb_quad_counter.sv
// -----------------------------------------------------------------------------
// tb_quad_counter
//
// Two quad_counter instances (wrap and saturate) share one set of inputs. A
// behavioural model tracks the encoder as a position index modulo 4 and the
// count as plain integer arithmetic; every cycle both instances are compared
// against it. Directed scenarios add hand-computed literal expectations, then
// a randomized phase exercises moves, glitches, loads, clears and resets.
// -----------------------------------------------------------------------------

module tb_quad_counter;

    localparam int W     = 8;
    localparam int MIN   = 0;
    localparam int MAX   = 99;
    localparam int INIT  = 50;
    localparam int STEPS = 4;
    localparam int EW    = 4;
    localparam int ERR_SAT = (1 << EW) - 1;

    logic         clk        = 1'b0;
    logic         rst        = 1'b0;
    logic         phase_a    = 1'b1;
    logic         phase_b    = 1'b1;
    logic         load       = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         clear_err  = 1'b0;

    logic [W-1:0]  count_w   [2];
    logic          step_w    [2];
    logic          cw_w      [2];
    logic          err_w     [2];
    logic [EW-1:0] err_cnt_w [2];
    logic          at_min_w  [2];
    logic          at_max_w  [2];

    always #5 clk = ~clk;

    quad_counter #(
        .p_WIDTH(W), .p_MIN(MIN), .p_MAX(MAX), .p_INIT(INIT),
        .p_MODE(0), .p_STEPS(STEPS), .p_ERR_WIDTH(EW)
    ) u_wrap (
        .clk(clk), .rst(rst),
        .i_phase_a(phase_a), .i_phase_b(phase_b),
        .i_load(load), .iv_load_value(load_value), .i_clear_err(clear_err),
        .ov_count(count_w[0]), .o_step(step_w[0]), .o_cw(cw_w[0]),
        .o_err(err_w[0]), .ov_err_cnt(err_cnt_w[0]),
        .o_at_min(at_min_w[0]), .o_at_max(at_max_w[0])
    );

    quad_counter #(
        .p_WIDTH(W), .p_MIN(MIN), .p_MAX(MAX), .p_INIT(INIT),
        .p_MODE(1), .p_STEPS(STEPS), .p_ERR_WIDTH(EW)
    ) u_sat (
        .clk(clk), .rst(rst),
        .i_phase_a(phase_a), .i_phase_b(phase_b),
        .i_load(load), .iv_load_value(load_value), .i_clear_err(clear_err),
        .ov_count(count_w[1]), .o_step(step_w[1]), .o_cw(cw_w[1]),
        .o_err(err_w[1]), .ov_err_cnt(err_cnt_w[1]),
        .o_at_min(at_min_w[1]), .o_at_max(at_max_w[1])
    );

    // ---------------------------------------------------------------- scoring
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------ model
    // Encoder position in CW order: 00=0, 10=1, 11=2, 01=3.
    function automatic int ab_to_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] idx_to_ab(input int idx);
        case (idx)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    function automatic int clamp(input int v);
        if (v < MIN) return MIN;
        if (v > MAX) return MAX;
        return v;
    endfunction

    function automatic int advance(input int c, input int d, input int mode);
        int range;
        range = MAX - MIN + 1;
        if (mode == 0) return MIN + ((c - MIN + d + range) % range);
        return clamp(c + d);
    endfunction

    int m_prev;
    bit m_primed;
    int m_sub;
    int m_count [2];
    bit m_step;
    bit m_cw;
    bit m_err;
    int m_err_cnt;

    task automatic model_clock();
        int cur;
        int delta;
        int detent;
        cur = ab_to_idx({phase_a, phase_b});
        if (rst) begin
            m_primed  = 1'b0;
            m_sub     = 0;
            m_count   = '{INIT, INIT};
            m_step    = 1'b0;
            m_cw      = 1'b0;
            m_err     = 1'b0;
            m_err_cnt = 0;
            return;
        end
        m_step = 1'b0;
        m_err  = 1'b0;
        if (!m_primed) begin
            m_primed = 1'b1;
            m_prev   = cur;
            return;
        end
        delta  = (cur - m_prev + 4) % 4;
        detent = 0;
        if (delta == 2) begin
            m_err = 1'b1;
            m_sub = 0;
        end else if (delta == 1) begin
            m_sub++;
        end else if (delta == 3) begin
            m_sub--;
        end
        if (m_sub == STEPS) begin
            m_sub  = 0;
            detent = 1;
        end else if (m_sub == -STEPS) begin
            m_sub  = 0;
            detent = -1;
        end
        if (load) begin
            m_sub = 0;
            for (int m = 0; m < 2; m++) m_count[m] = clamp(int'(load_value));
        end else if (detent != 0) begin
            m_step = 1'b1;
            m_cw   = (detent > 0);
            for (int m = 0; m < 2; m++) m_count[m] = advance(m_count[m], detent, m);
        end
        if (clear_err) m_err_cnt = 0;
        else if (m_err && m_err_cnt < ERR_SAT) m_err_cnt++;
        m_prev = cur;
    endtask

    // --------------------------------------------------- per-cycle compare
    int step_pulses [2] = '{0, 0};
    int err_pulses      = 0;

    initial begin
        forever begin
            @(posedge clk);
            model_clock();
            #1;
            for (int m = 0; m < 2; m++) begin
                check($sformatf("count[%0d]", m),   count_w[m],   m_count[m]);
                check($sformatf("step[%0d]", m),    step_w[m],    m_step);
                check($sformatf("cw[%0d]", m),      cw_w[m],      m_cw);
                check($sformatf("err[%0d]", m),     err_w[m],     m_err);
                check($sformatf("err_cnt[%0d]", m), err_cnt_w[m], m_err_cnt);
                check($sformatf("at_min[%0d]", m),  at_min_w[m],  m_count[m] == MIN);
                check($sformatf("at_max[%0d]", m),  at_max_w[m],  m_count[m] == MAX);
                if (step_w[m] === 1'b1) step_pulses[m]++;
            end
            if (err_w[0] === 1'b1) err_pulses++;
        end
    end

    // --------------------------------------------------------------- stimulus
    int pos = 2;   // current AB = 11

    // move: 0 hold, 1 CW, 3 CCW, 2 illegal (both bits flip)
    task automatic drive(input int move, input bit ld = 1'b0,
                         input logic [W-1:0] v = '0, input bit clr = 1'b0);
        @(negedge clk);
        pos = (pos + move) % 4;
        {phase_a, phase_b} = idx_to_ab(pos);
        load       = ld;
        load_value = v;
        clear_err  = clr;
    endtask

    task automatic moves(input int move, input int n);
        for (int k = 0; k < n; k++) drive(move);
    endtask

    // Let the last driven value be sampled, then look at the result.
    task automatic settle();
        @(posedge clk);
        #2;
        load      = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst       = 1'b1;
        load      = 1'b0;
        clear_err = 1'b0;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_pulses();
        step_pulses = '{0, 0};
        err_pulses  = 0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("reset count", count_w[0], INIT);
        check("reset count sat", count_w[1], INIT);
        check("reset err_cnt", err_cnt_w[0], 0);
        check("reset step", step_w[0], 0);
        check("reset cw", cw_w[0], 0);
        check("reset err", err_w[0], 0);

        // Release with AB = 11, then one CW detent
        rst = 1'b0;
        @(negedge clk);
        clear_pulses();
        moves(1, 4);
        settle();
        check("cw detent steps", step_pulses[0], 1);
        check("cw detent dir", cw_w[0], 1);
        check("cw detent count", count_w[0], 51);
        check("cw detent no err", err_pulses, 0);
        check("model after cw detent", m_count[0], 51);

        // Partial detent cancelled by reversal, then a full CCW detent
        clear_pulses();
        moves(1, 2);
        moves(3, 2);
        moves(3, 4);
        settle();
        check("ccw detent steps", step_pulses[0], 1);
        check("ccw detent dir", cw_w[0], 0);
        check("ccw detent count", count_w[0], 50);
        check("model after ccw detent", m_count[0], 50);

        // Limits: wrap goes round, saturate holds
        drive(0, 1'b1, 8'd99);
        moves(1, 4);
        settle();
        check("wrap past max", count_w[0], 0);
        check("wrap at_min", at_min_w[0], 1);
        check("sat hold max", count_w[1], 99);
        moves(3, 4);
        settle();
        check("wrap below min", count_w[0], 99);
        check("wrap at_max", at_max_w[0], 1);
        check("sat step down", count_w[1], 98);

        // Clamped load and CW detent at max in saturate mode
        drive(0, 1'b1, 8'd200);
        settle();
        check("load clamp wrap", count_w[0], 99);
        check("load clamp sat", count_w[1], 99);
        clear_pulses();
        moves(1, 4);
        settle();
        check("sat cw at max count", count_w[1], 99);
        check("sat cw at max step", step_pulses[1], 1);
        check("sat cw at max dir", cw_w[1], 1);
        check("wrap cw at max count", count_w[0], 0);

        // Illegal transitions: error pulses and saturating error count
        clear_pulses();
        moves(2, 17);
        settle();
        check("err pulses", err_pulses, 17);
        check("err_cnt saturated", err_cnt_w[0], 15);
        check("err count unchanged wrap", count_w[0], 0);
        check("err count unchanged sat", count_w[1], 99);
        drive(2, 1'b0, '0, 1'b1);
        settle();
        check("clear beats error", err_cnt_w[0], 0);
        check("err pulse with clear", err_w[0], 1);

        // Load coincident with a completing detent
        clear_pulses();
        moves(1, 3);
        drive(1, 1'b1, 8'd10);
        settle();
        check("load over detent count", count_w[0], 10);
        check("load over detent sat", count_w[1], 10);
        check("load over detent step", step_pulses[0], 0);
        moves(1, 3);
        settle();
        check("sub cleared by load", step_pulses[0], 0);
        moves(1, 1);
        settle();
        check("detent after load", step_pulses[0], 1);
        check("count after load detent", count_w[0], 11);

        // Saturate at min for CCW
        drive(0, 1'b1, 8'd0);
        moves(3, 4);
        settle();
        check("sat ccw at min", count_w[1], 0);
        check("wrap ccw at min", count_w[0], 99);

        // Reset mid-detent discards the partial sub-count
        moves(1, 2);
        do_reset(2);
        @(negedge clk);
        clear_pulses();
        moves(1, 2);
        settle();
        check("partial lost on reset", step_pulses[0], 0);
        check("count after reset", count_w[0], INIT);
        moves(1, 2);
        settle();
        check("detent after reset", step_pulses[0], 1);
        check("count after reset detent", count_w[0], INIT + 1);

        // Randomized phase against the model
        for (int i = 0; i < 4000; i++) begin
            int r;
            int mv;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                r = $urandom_range(0, 99);
                if (r < 60)      mv = 1;
                else if (r < 82) mv = 3;
                else if (r < 92) mv = 0;
                else             mv = 2;
                drive(mv, ($urandom_range(0, 19) == 0), W'($urandom_range(0, 255)),
                      ($urandom_range(0, 29) == 0));
            end
        end
        settle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/quad_counter.md
QUAD_COUNTER -- requirements
Module: quad_counter

Interface
REQ-001 Parameter p_WIDTH, default 8: position counter width in bits.
REQ-002 Parameter p_MIN, default 0: lowest count value, unsigned.
REQ-003 Parameter p_MAX, default 255: highest count value, unsigned; p_MIN < p_MAX < 2^p_WIDTH.
REQ-004 Parameter p_INIT, default 0: count value after reset; p_MIN <= p_INIT <= p_MAX.
REQ-005 Parameter p_MODE, default 0: 0 = wrap at the limits, 1 = saturate at the limits.
REQ-006 Parameter p_STEPS, default 4: valid quadrature transitions per detent; legal values 1, 2 or 4.
REQ-007 Parameter p_ERR_WIDTH, default 4: error counter width.
REQ-008 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-009 RST  in  1  asynchronous, active-high reset.
REQ-010 i_phase_a  in  1  encoder phase A, already synchronised to CLK.
REQ-011 i_phase_b  in  1  encoder phase B, already synchronised to CLK.
REQ-012 i_load  in  1  single-cycle strobe that loads iv_load_value into the count.
REQ-013 iv_load_value  in  p_WIDTH  value to load.
REQ-014 i_clear_err  in  1  clears the error counter.
REQ-015 ov_count  out  p_WIDTH  current position count.
REQ-016 o_step  out  1  one-cycle pulse per completed detent.
REQ-017 o_cw  out  1  direction of the last detent (1 = CW); held between steps.
REQ-018 o_err  out  1  one-cycle pulse on an illegal transition.
REQ-019 ov_err_cnt  out  p_ERR_WIDTH  saturating count of illegal transitions.
REQ-020 o_at_min  out  1  high while ov_count == p_MIN (combinational from the count register).
REQ-021 o_at_max  out  1  high while ov_count == p_MAX (combinational from the count register).

Function
REQ-022 Phase state AB = {i_phase_a, i_phase_b}; CW sequence is 00->10->11->01->00; CCW is the reverse.
REQ-023 Each edge compares the current AB with registered r_prev_ab, then sets r_prev_ab <= AB.
REQ-024 Unchanged AB: no action.
REQ-025 One-bit change in CW order: signed sub-counter +1.
REQ-026 One-bit change in CCW order: signed sub-counter -1.
REQ-027 Both bits changed: o_err pulses, sub-counter clears to 0, ov_err_cnt increments, saturating at all-ones, and count is unchanged.
REQ-028 When the sub-counter would reach +p_STEPS, it clears instead and a CW detent occurs.
REQ-029 When the sub-counter would reach -p_STEPS, it clears instead and a CCW detent occurs.
REQ-030 A direction reversal mid-detent decrements or increments the sub-counter normally, so partial detents cancel.
REQ-031 Detent: o_step = 1 for one cycle, o_cw = direction, and count is updated on the same edge as the sampling; latency 1 edge from a new AB to visible outputs.
REQ-032 Wrap mode: CW at p_MAX goes to p_MIN; CCW at p_MIN goes to p_MAX.
REQ-033 Saturate mode: CW at p_MAX holds and CCW at p_MIN holds; o_step and o_cw still update.
REQ-034 i_load: count <= iv_load_value clamped to [p_MIN, p_MAX]; the sub-counter clears.
REQ-035 i_load has priority over a simultaneous detent; that detent is discarded with o_step = 0, while r_prev_ab still updates.
REQ-036 i_clear_err: ov_err_cnt <= 0; it takes priority over a simultaneous error (result 0), but o_err still pulses.
REQ-037 All arithmetic is performed with one extra bit, so there is no unintended overflow at p_MAX = 2^p_WIDTH - 1.

Reset
REQ-038 While RST is high: ov_count = p_INIT, sub-counter = 0, o_step = 0, o_cw = 0, o_err = 0, ov_err_cnt = 0.
REQ-039 A valid flag r_primed clears on reset.
REQ-040 The first edge after RST deasserts only loads r_prev_ab from AB and sets r_primed; no count or error can occur on that edge.
REQ-041 Reset asserted mid-detent discards the partial sub-count.

Verification (p_WIDTH=8, p_MIN=0, p_MAX=99, p_INIT=50, p_STEPS=4, p_ERR_WIDTH=4)
REQ-042 Reset release with AB = 11, then 4 CW transitions -> exactly one o_step, o_cw = 1, ov_count = 51, o_err never asserted.
REQ-043 From 51: 2 CW, then 2 CCW, then 4 CCW transitions -> exactly one o_step, o_cw = 0, ov_count = 50.
REQ-044 Wrap mode: load 99, then 1 CW detent -> ov_count = 0, o_at_min = 1; then 1 CCW detent -> 99, o_at_max = 1.
REQ-045 Saturate mode: load 200 -> ov_count = 99; 1 CW detent -> ov_count stays 99, o_step pulses.
REQ-046 17 illegal transitions (00<->11) -> 17 o_err pulses, ov_err_cnt = 15, ov_count unchanged; i_clear_err together with an error -> ov_err_cnt = 0.
REQ-047 i_load of 10 on the same edge as a completing detent -> ov_count = 10, o_step = 0, sub-counter = 0.
